// File: rtl/instr_loader_pkg.sv
// Shared types and defaults for the instruction-stream loader.
package instr_loader_pkg;
   localparam int DEF_DEPTH  = 1024;
   localparam int DEF_WORD_W = 32;
   localparam int DEF_ADDR_W = 10;

   // Cleared image words decode as sll $0 (a NOP) on the CPU.
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/loader_checksum.sv
// Running mod-2^WORD_W sum of accepted program words, with synchronous clear.
module loader_checksum
   import instr_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_en,
   input  logic [WORD_W-1:0] i_data,
   output logic [WORD_W-1:0] o_sum
);
   logic [WORD_W-1:0] r_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sum <= '0;
      end else if (i_clear) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum + i_data;
      end
   end

   assign o_sum = r_sum;
endmodule

// File: rtl/instr_stream_loader.sv
// Host-fed writer for the CPU's packed instruction image; holds the CPU in reset until loaded.
// Define LOADER_CHECKSUM_EN to add a checksum port and an expected-sum gate on CPU release.
module instr_stream_loader
   import instr_loader_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_start,
   input  logic [ADDR_W:0]         load_count,
   input  logic                    in_valid,
   input  logic [WORD_W-1:0]       in_data,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [DEPTH*WORD_W-1:0] instruction_stream,
   output logic                    cpu_hold,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDR_W:0]         words_loaded
`ifdef LOADER_CHECKSUM_EN
   ,
   input  logic [WORD_W-1:0]       expected_sum,
   output logic [WORD_W-1:0]       checksum
`endif
);
   localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);

   state_t            r_state;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_target;
   logic              r_in_ready;
   logic              r_cpu_hold;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_idle_like;
   logic              w_legal;
   logic              w_start_ok;
   logic              w_start_bad;
   logic              w_xfer;
   logic [ADDR_W:0]   w_count_inc;
   logic              w_final;
   logic              w_sum_ok;

   assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_legal     = (load_count != '0) && (load_count <= MAX_COUNT);
   assign w_start_ok  = w_idle_like && load_start && w_legal;
   assign w_start_bad = w_idle_like && load_start && !w_legal;
   assign w_xfer      = (r_state == ST_LOAD) && in_valid;
   assign w_count_inc = r_count + 1'b1;
   assign w_final     = w_xfer && ((w_count_inc == r_target) || in_last);

`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] w_sum;
   logic [WORD_W-1:0] w_sum_next;

   loader_checksum #(
      .WORD_W (WORD_W)
   ) u_checksum (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_start_ok),
      .i_en    (w_xfer),
      .i_data  (in_data),
      .o_sum   (w_sum)
   );

   // The final word is not yet in the accumulator when DONE is decided.
   assign w_sum_next = w_sum + in_data;
   assign w_sum_ok   = (w_sum_next == expected_sum);
   assign checksum   = w_sum;
`else
   assign w_sum_ok   = 1'b1;
`endif

   // One flop word per image slot so a legal start can clear the whole image in one edge.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [WORD_W-1:0] r_word;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_word <= WORD_W'(NOP_WORD);
            end else if (w_start_ok) begin
               r_word <= WORD_W'(NOP_WORD);
            end else if (w_xfer && (r_wptr == ADDR_W'(gi))) begin
               r_word <= in_data;
            end
         end

         assign instruction_stream[gi*WORD_W +: WORD_W] = r_word;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_wptr     <= '0;
         r_count    <= '0;
         r_target   <= '0;
         r_in_ready <= 1'b0;
         r_cpu_hold <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_ok) begin
                  r_state    <= ST_LOAD;
                  r_wptr     <= '0;
                  r_count    <= '0;
                  r_target   <= load_count;
                  r_in_ready <= 1'b1;
                  r_cpu_hold <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end else if (w_start_bad) begin
                  r_err <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (w_xfer) begin
                  r_wptr  <= r_wptr + 1'b1;
                  r_count <= w_count_inc;
                  if (w_final) begin
                     r_state    <= ST_DONE;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_cpu_hold <= !w_sum_ok;
                     r_err      <= !w_sum_ok;
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b0;
               r_cpu_hold <= 1'b1;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign cpu_hold     = r_cpu_hold;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign words_loaded = r_count;
endmodule

// File: tb/tb_instr_stream_loader.sv
// Self-checking bench for instr_stream_loader: per-cycle model comparison plus literal pins.
module tb_instr_stream_loader;
   localparam int DEPTH  = 1024;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 10;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    load_start = 1'b0;
   logic [ADDR_W:0]         load_count = '0;
   logic                    in_valid = 1'b0;
   logic [WORD_W-1:0]       in_data = '0;
   logic                    in_last = 1'b0;
   logic                    in_ready;
   logic [DEPTH*WORD_W-1:0] instruction_stream;
   logic                    cpu_hold;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic [ADDR_W:0]         words_loaded;
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]       expected_sum = '0;
   logic [WORD_W-1:0]       checksum;
`endif

   int n_checks = 0;
   int n_errors = 0;

   instr_stream_loader #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .load_start         (load_start),
      .load_count         (load_count),
      .in_valid           (in_valid),
      .in_data            (in_data),
      .in_last            (in_last),
      .in_ready           (in_ready),
      .instruction_stream (instruction_stream),
      .cpu_hold           (cpu_hold),
      .busy               (busy),
      .done               (done),
      .err                (err),
      .words_loaded       (words_loaded)
`ifdef LOADER_CHECKSUM_EN
      ,
      .expected_sum       (expected_sum),
      .checksum           (checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input int idx);
      return instruction_stream[idx*WORD_W +: WORD_W];
   endfunction

   // Model: phase 0=idle 1=loading 2=done, image as a word array, counters as ints.
   int          m_phase;
   logic [31:0] m_img [DEPTH];
   int          m_cnt;
   int          m_target;
   logic        m_err;
   logic        m_hold_bad;
   logic [31:0] m_sum;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase <= 0;
         for (int i = 0; i < DEPTH; i++) m_img[i] <= 32'h0;
         m_cnt      <= 0;
         m_target   <= 0;
         m_err      <= 1'b0;
         m_hold_bad <= 1'b0;
         m_sum      <= 32'h0;
      end else begin
         m_err <= 1'b0;
         if (m_phase == 1) begin
            if (in_valid) begin
               m_img[m_cnt] <= in_data;
               m_cnt        <= m_cnt + 1;
               m_sum        <= m_sum + in_data;
               if ((m_cnt + 1 == m_target) || in_last) begin
                  m_phase <= 2;
`ifdef LOADER_CHECKSUM_EN
                  if (32'(m_sum + in_data) != expected_sum) begin
                     m_hold_bad <= 1'b1;
                     m_err      <= 1'b1;
                  end
`endif
               end
            end
         end else if (load_start) begin
            if (load_count >= 1 && load_count <= DEPTH) begin
               for (int i = 0; i < DEPTH; i++) m_img[i] <= 32'h0;
               m_cnt      <= 0;
               m_target   <= int'(load_count);
               m_phase    <= 1;
               m_hold_bad <= 1'b0;
               m_sum      <= 32'h0;
            end else begin
               m_err <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      int bad_idx;
      chk("in_ready", in_ready, m_phase == 1);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("cpu_hold", cpu_hold, (m_phase != 2) || m_hold_bad);
      chk("err", err, m_err);
      chk("words_loaded", words_loaded, m_cnt);
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
      bad_idx = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (bad_idx < 0 && word_at(i) !== m_img[i]) bad_idx = i;
      end
      if (bad_idx < 0) chk("image", 64'd0, 64'd0 + (bad_idx < 0 ? 0 : 1));
      else chk("image_word", word_at(bad_idx), m_img[bad_idx]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int n);
      load_start = 1'b1;
      load_count = 11'(n);
      tick();
      load_start = 1'b0;
      load_count = '0;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      tick();
      $display("reset released");
      chk("rst_cpu_hold", cpu_hold, 1'b1);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_image_zero", instruction_stream == '0, 1'b1);

      start_load(3);
      send(32'h2008_0005, 1'b0);
      send(32'h2009_0007, 1'b0);
      send(32'h0109_5020, 1'b0);
      $display("load 3 words: loaded=%0d done=%0b", words_loaded, done);
      chk("full_w0", word_at(0), 32'h2008_0005);
      chk("full_w1", word_at(1), 32'h2009_0007);
      chk("full_w2", word_at(2), 32'h0109_5020);
      chk("full_w3", word_at(3), 32'h0);
      chk("full_done", done, 1'b1);
      chk("full_release", cpu_hold, 1'b0);
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_count", words_loaded, 11'd3);

      start_load(8);
      chk("reload_hold", cpu_hold, 1'b1);
      send(32'hAAAA_0001, 1'b0);
      tick();
      send(32'hAAAA_0002, 1'b1);
      $display("load 8 with early last: loaded=%0d done=%0b", words_loaded, done);
      chk("early_count", words_loaded, 11'd2);
      chk("early_done", done, 1'b1);
      chk("early_w1", word_at(1), 32'hAAAA_0002);
      chk("early_w2_cleared", word_at(2), 32'h0);

      start_load(0);
      $display("illegal start count=0: err=%0b", err);
      chk("illegal0_err", err, 1'b1);
      chk("illegal0_done", done, 1'b1);
      tick();
      chk("illegal0_err_drop", err, 1'b0);
      start_load(1025);
      $display("illegal start count=1025: err=%0b", err);
      chk("illegal1025_err", err, 1'b1);
      chk("illegal1025_img", word_at(0), 32'hAAAA_0001);
      tick();

      start_load(1024);
      for (int i = 0; i < DEPTH; i++) send(32'hC000_0000 | 32'(i), 1'b0);
      $display("load 1024 words: loaded=%0d done=%0b", words_loaded, done);
      chk("fill_last", instruction_stream[32767:32736], 32'hC000_03FF);
      chk("fill_first", word_at(0), 32'hC000_0000);
      chk("fill_count", words_loaded, 11'd1024);
      chk("fill_done", done, 1'b1);

      start_load(1);
      chk("reload1_hold", cpu_hold, 1'b1);
      chk("reload1_cleared", word_at(1023), 32'h0);
      send(32'h1234_5678, 1'b0);
      $display("load 1 word: loaded=%0d done=%0b", words_loaded, done);
      chk("reload1_w0", word_at(0), 32'h1234_5678);
      chk("reload1_done", done, 1'b1);

      start_load(5);
      send(32'h5555_0001, 1'b0);
      load_start = 1'b1;
      load_count = '0;
      tick();
      chk("load_start_in_load_no_err", err, 1'b0);
      load_count = 11'd2;
      in_valid   = 1'b1;
      in_data    = 32'h5555_0002;
      tick();
      load_start = 1'b0;
      load_count = '0;
      in_valid   = 1'b0;
      chk("xfer_wins_count", words_loaded, 11'd2);
      chk("xfer_wins_busy", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      $display("mid-load reset after 2 of 5");
      chk("midrst_image", instruction_stream == '0, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_hold", cpu_hold, 1'b1);
      chk("midrst_count", words_loaded, 11'd0);
      tick();
      rst = 1'b1;
      tick();

`ifdef LOADER_CHECKSUM_EN
      expected_sum = 32'd6;
      start_load(3);
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b0);
      $display("checksum load expected 6: sum=%0d hold=%0b", checksum, cpu_hold);
      chk("cks_sum", checksum, 32'd6);
      chk("cks_release", cpu_hold, 1'b0);
      chk("cks_err", err, 1'b0);
      expected_sum = 32'd7;
      start_load(3);
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b0);
      $display("checksum load expected 7: sum=%0d hold=%0b err=%0b", checksum, cpu_hold, err);
      chk("cks_bad_err", err, 1'b1);
      chk("cks_bad_hold", cpu_hold, 1'b1);
      chk("cks_bad_done", done, 1'b1);
      tick();
      chk("cks_bad_err_drop", err, 1'b0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Writer side of the CPU's flat instruction-stream interface.
- Accepts program words over a valid/ready stream and assembles the packed instruction image that drives the CPU's instruction_stream input.
- Holds the CPU in reset until the program is fully loaded.
- Sits between the test/boot host and the cpu top.

Parameters:
DEPTH, 1024, number of instruction words in the image
WORD_W, 32, instruction word width
ADDR_W, 10, word-pointer width; must equal clog2(DEPTH)

Ports:
clk  input  1  single clock
rst  input  1  reset; asynchronous, active-low
load_start  input  1  one-cycle request to begin a new program load
load_count  input  ADDR_W+1  number of words to load, sampled at load_start; legal range 1..DEPTH
in_valid  input  1  host word valid
in_data  input  WORD_W  host instruction word
in_last  input  1  marks the final word, allowing an early end before load_count
in_ready  output  1  loader accepts a word this cycle
instruction_stream  output  DEPTH*WORD_W  packed image; word i at bits [i*WORD_W +: WORD_W]
cpu_hold  output  1  high holds the CPU in reset
busy  output  1  high in LOAD
done  output  1  high in DONE
err  output  1  one-cycle pulse on an illegal load_start
words_loaded  output  ADDR_W+1  count of words accepted in the current or last load

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Reset values (rst=0, immediate):
  - state=IDLE, image all zeros (sll $0 NOP), wptr=0, words_loaded=0
  - in_ready=0, cpu_hold=1, busy=0, done=0, err=0
- IDLE:
  - in_ready=0, cpu_hold=1.
  - load_start with 1<=load_count<=DEPTH: clear the image to zero, wptr=0, words_loaded=0, latch the target count, go to LOAD next cycle.
  - load_start with load_count==0 or >DEPTH: stay in IDLE and pulse err for one cycle.
- LOAD:
  - in_ready=1, busy=1, cpu_hold=1.
  - Handshake: a word transfers on a clock edge where in_valid&&in_ready. It is written to image[wptr], then wptr and words_loaded each increment by 1.
  - in_data and in_last are sampled only on a transfer.
  - Go to DONE on the transfer that makes words_loaded equal the target, or on any transfer with in_last=1.
  - Words not written remain zero.
  - in_ready drops in the cycle after the final transfer.
  - No wrap: wptr never exceeds target-1, so DEPTH words fill exactly.
- DONE:
  - done=1, cpu_hold=0, in_ready=0. The image is stable; CPU reset releases 1 cycle after the final transfer.
  - in_valid is ignored.
  - load_start (legal) behaves as from IDLE: cpu_hold=1 in the next cycle, image cleared, go to LOAD.
  - load_start (illegal) pulses err and stays in DONE with the image intact.
- load_start during LOAD: ignored, no err.
- A transfer and load_start in the same cycle: the transfer wins.
- State encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2; 2'd3 is unreachable and recovers to IDLE.
- rst asserted mid-load: returns to reset values immediately and discards the partial image.
- Outputs are registered; instruction_stream comes straight from storage flops.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [WORD_W-1:0]: the mod-2^WORD_W sum of all words accepted in the current load, cleared on a legal load_start, reset 0.
  - Adds input expected_sum [WORD_W-1:0], sampled on the DONE transition.
  - On mismatch, the loader enters DONE with cpu_hold kept at 1 and err pulsed once.
- Undefined: neither port exists, and DONE always releases cpu_hold.

Decomposition:
- Shared package instr_loader_pkg:
  - state typedef (IDLE/LOAD/DONE)
  - DEPTH, WORD_W and ADDR_W defaults
  - NOP_WORD=32'h0000_0000 reset fill constant
- Sub-module loader_checksum: an accumulator with clear and enable, instantiated only under LOADER_CHECKSUM_EN.
- Everything else stays in one module.

Test Plan:
- Reset values: hold rst=0 for 3 cycles, release -> cpu_hold=1, in_ready=0, instruction_stream all zero, done=0.
- Full-count load: load_start, load_count=3, stream 32'h2008_0005, 32'h2009_0007, 32'h0109_5020 back-to-back -> words 0..2 match, word 3 = 0, done=1 and cpu_hold=0 one cycle after the third transfer, words_loaded=3.
- Backpressure, early end and full fill:
  - load_count=8 with in_valid toggled 1/0 and in_last on the 2nd transfer -> only 2 words written, DONE entered, words_loaded=2.
  - load_count=1024 -> word 1023 at bits [32767:32736], no wrap into word 0.
- Illegal starts: load_start with load_count=0, then with 1025 -> err pulses once each, state unchanged, image unchanged.
- Reload and mid-load reset:
  - In DONE, load_start, load_count=1 -> cpu_hold=1 next cycle, old image cleared, new word at index 0.
  - rst=0 after 2 of 5 words -> image zero, IDLE.
- Checksum (LOADER_CHECKSUM_EN defined): load words 1, 2, 3 with expected_sum=6 -> checksum=6, cpu_hold=0. Repeat with expected_sum=7 -> err pulse, cpu_hold=1.
